pc_stack_unit: RTL and testbench

Parametrised program-counter unit for the accumulator processor, the successor to the fixed-width PC block. It holds the PC register and applies unconditional writes and beq/bne branches selected from ALU result, jump target or latched ALU output. It adds a hardware return-address stack so call/return instructions need no memory traffic. It sits beside the ALU subsystem and drives the PC operand into the ALU source mux.

---
 rtl/pc_stack_unit.sv | 147 ++++++++++++++
 tb/tb_pc_stack_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a hardware return-address stack.
// The PC updates when written unconditionally or on a taken beq/bne branch.
// Call pushes the old PC, PCSrc=11 returns from the stack top, and
// Call together with PCSrc=11 swaps the PC with the stack top.
// Overflow and underflow set a sticky error flag that only reset clears.
module pc_stack_unit #(
  parameter int unsigned           WIDTH    = 16,
  parameter int unsigned           DEPTH    = 8,
  parameter logic [WIDTH-1:0]      RESET_PC = '0,
  localparam int unsigned          DW       = $clog2(DEPTH + 1),
  localparam int unsigned          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic             bneOrbeq,
  input  logic             Zero,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] PCInA,
  input  logic [WIDTH-1:0] PCInB,
  input  logic [WIDTH-1:0] PCInC,
  input  logic             Call,
  output logic [WIDTH-1:0] PCOut,
  output logic [WIDTH-1:0] TOS,
  output logic [DW-1:0]    Depth,
  output logic             Full,
  output logic             Empty,
  output logic             StackErr
);

  // Architectural state
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Decoded and next-state helpers
  logic             pc_en_s;
  logic             full_s;
  logic             empty_s;
  logic [AW-1:0]    top_idx_s;
  logic [AW-1:0]    push_idx_s;
  logic [WIDTH-1:0] tos_s;
  logic [WIDTH-1:0] sel_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [WIDTH-1:0] mem_wdata_s;

  assign pc_en_s    = PCWrite | (Branch & (Zero ^ bneOrbeq));
  assign full_s     = (depth_q == DW'(DEPTH));
  assign empty_s    = (depth_q == {DW{1'b0}});
  assign push_idx_s = AW'(depth_q);
  assign top_idx_s  = AW'(depth_q) - AW'(1'b1);

  // Stack top as seen from outside; reads zero while the stack is empty
  always_comb begin
    tos_s = {WIDTH{1'b0}};
    if (empty_s) begin
      tos_s = {WIDTH{1'b0}};
    end else begin
      tos_s = mem_q[top_idx_s];
    end
  end

  // Next-PC source select for the non-return encodings
  always_comb begin
    sel_s = pc_q;
    case (PCSrc)
      2'b00:   sel_s = PCInA;
      2'b01:   sel_s = PCInB;
      2'b10:   sel_s = PCInC;
      default: sel_s = pc_q;
    endcase
  end

  // Next PC, depth, error flag and stack write for push/pop/swap
  always_comb begin
    pc_d        = pc_q;
    depth_d     = depth_q;
    err_d       = err_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = {AW{1'b0}};
    mem_wdata_s = pc_q;
    if (pc_en_s) begin
      if (PCSrc != 2'b11) begin
        pc_d = sel_s;
        if (Call) begin
          if (full_s) begin
            // Push is dropped but the jump still happens
            err_d = 1'b1;
          end else begin
            mem_we_s    = 1'b1;
            mem_waddr_s = push_idx_s;
            depth_d     = depth_q + DW'(1'b1);
          end
        end else begin
          depth_d = depth_q;
        end
      end else begin
        if (empty_s) begin
          // Return/swap with nothing on the stack leaves the PC alone
          err_d = 1'b1;
        end else begin
          pc_d = tos_s;
          if (Call) begin
            // Swap: old PC replaces the entry being returned to
            mem_we_s    = 1'b1;
            mem_waddr_s = top_idx_s;
          end else begin
            depth_d = depth_q - DW'(1'b1);
          end
        end
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // PC, occupancy and sticky error registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      depth_q <= {DW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage; contents are meaningless until written so no reset
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign PCOut    = pc_q;
  assign Depth    = depth_q;
  assign StackErr = err_q;
  assign Full     = full_s;
  assign Empty    = empty_s;
  assign TOS      = tos_s;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Testbench for pc_stack_unit: directed scenarios plus random traffic,
// predicted by a queue-based stack model and checked by a monitor process.
module tb_pc_stack_unit;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int DW = $clog2(D + 1);

  logic          CLK = 1'b0;
  logic          reset;
  logic          PCWrite, Branch, bneOrbeq, Zero, Call;
  logic [1:0]    PCSrc;
  logic [W-1:0]  PCInA, PCInB, PCInC;
  logic [W-1:0]  PCOut, TOS;
  logic [DW-1:0] Depth;
  logic          Full, Empty, StackErr;

  pc_stack_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .reset(reset), .PCWrite(PCWrite), .Branch(Branch),
    .bneOrbeq(bneOrbeq), .Zero(Zero), .PCSrc(PCSrc), .PCInA(PCInA),
    .PCInB(PCInB), .PCInC(PCInC), .Call(Call), .PCOut(PCOut), .TOS(TOS),
    .Depth(Depth), .Full(Full), .Empty(Empty), .StackErr(StackErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] pc;
    int           depth;
    logic [W-1:0] tos;
    logic         full;
    logic         empty;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_stack[$];
  logic [W-1:0] m_pc;
  logic         m_err;
  bit           in_reset;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.pc    = m_pc;
    e.depth = m_stack.size();
    e.tos   = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : 16'h0000;
    e.full  = (m_stack.size() == D);
    e.empty = (m_stack.size() == 0);
    e.err   = m_err;
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected result
  task automatic step(input bit pcw, input bit br, input bit boe, input bit z,
                      input logic [1:0] src, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] c, input bit call);
    bit en;
    logic [W-1:0] top;
    @(negedge CLK);
    PCWrite = pcw; Branch = br; bneOrbeq = boe; Zero = z;
    PCSrc = src; PCInA = a; PCInB = b; PCInC = c; Call = call;
    en = pcw || (br && (z != boe));
    if (en) begin
      if (src != 2'b11) begin
        if (call) begin
          if (m_stack.size() == D) m_err = 1'b1;
          else m_stack.push_back(m_pc);
        end
        m_pc = (src == 2'b00) ? a : (src == 2'b01) ? b : c;
      end else if (m_stack.size() == 0) begin
        m_err = 1'b1;
      end else begin
        top = m_stack[m_stack.size()-1];
        if (call) m_stack[m_stack.size()-1] = m_pc;
        else void'(m_stack.pop_back());
        m_pc = top;
      end
    end
    exp_q.push_back(model_view());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic set_pc(input logic [W-1:0] v);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, v, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    32'(PCOut),    32'h0);
    check({tag, "_depth"}, 32'(Depth),    32'h0);
    check({tag, "_empty"}, 32'(Empty),    32'h1);
    check({tag, "_full"},  32'(Full),     32'h0);
    check({tag, "_tos"},   32'(TOS),      32'h0);
    check({tag, "_err"},   32'(StackErr), 32'h0);
  endtask

  // Assert reset between clock edges and check it takes effect at once
  task automatic do_reset(input string tag);
    @(posedge CLK);
    #3;
    in_reset = 1'b1;
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    m_stack.delete();
    m_pc = 16'h0000;
    m_err = 1'b0;
    exp_q.delete();
    PCWrite = 1'b0; Branch = 1'b0; Call = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: after every active edge compare DUT state with the next prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (!in_reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",    32'(PCOut),    32'(e.pc));
        check("depth", 32'(Depth),    32'(e.depth));
        check("tos",   32'(TOS),      32'(e.tos));
        check("full",  32'(Full),     32'(e.full));
        check("empty", 32'(Empty),    32'(e.empty));
        check("err",   32'(StackErr), 32'(e.err));
      end
    end
  end

  initial begin
    int guard;
    in_reset = 1'b1;
    reset = 1'b0;
    PCWrite = 1'b0; Branch = 1'b0; bneOrbeq = 1'b0; Zero = 1'b0; Call = 1'b0;
    PCSrc = 2'b00; PCInA = '0; PCInB = '0; PCInC = '0;
    m_pc = 16'h0000; m_err = 1'b0;
    #12;
    check_reset_outputs("init");
    @(negedge CLK);
    reset = 1'b1;
    in_reset = 1'b0;

    // Unconditional write then hold with ignored Call/PCSrc
    set_pc(16'h0002);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'(i % 2), 1'(i % 2), 2'(i % 4), 16'(i), 16'h1234, 16'h5678, 1'b1);

    // Branches
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0, 16'h0, 16'h0040, 1'b0);
    set_pc(16'h0010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 16'h0, 16'h0, 16'h0040, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 16'h0, 16'h0, 16'h0040, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0, 16'h0, 16'h0080, 1'b0);

    // Call then return
    set_pc(16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0, 16'h0100, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0, 16'h0, 1'b0);

    // Nine calls: last one overflows
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0, 16'(16'h0200 + 2 * i), 16'h0, 1'b1);
    // Drain with back-to-back pops and one underflow
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0, 16'h0, 1'b0);

    // Pop on empty right after reset
    do_reset("rst1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0, 16'h0, 1'b0);

    // Swap with two entries
    do_reset("rst2");
    set_pc(16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0, 16'h0020, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0, 16'h0080, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0, 16'h0, 1'b1);
    // Push immediately followed by pop
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0300, 16'h0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0, 16'h0, 1'b0);

    // Mid-operation reset with PC=0x0040, Depth=3
    do_reset("rst3");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0, 16'(16'h0010 * (i + 2)), 16'h0, 1'b1);
    do_reset("rst4");
    // Swap on empty stack
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0, 16'h0, 1'b1);
    do_reset("rst5");

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
           16'($urandom), 1'($urandom_range(0, 2) == 0));
    idle();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
